pim_conv_sched: RTL and testbench
=================================

Name: pim_conv_sched

Overview:
Round-robin scheduler that shares one bit-serial PIM crossbar conv engine among NUM_REQ requesters. It accepts one job at a time: an input feature vector plus a crossbar column address. It streams the job's bit-planes into the engine one per cycle and shift-accumulates the engine's ADC partial sums into a full-precision result. The result is returned with the requester ID over a valid/ready response channel. It sits between the layer-level dataflow logic and the crossbar engine instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
INPUT_SIZE, 9, feature elements per job (crossbar rows)
INPUT_P, 8, bits per feature element; equals the number of bit-planes per job
ADC_P, 4, engine ADC output width
ADDR_W, 1, crossbar column address width
ID_W, clogb2(NUM_REQ), response ID width
ACC_W, ADC_P+INPUT_P, accumulated result width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_feature  in  NUM_REQ*INPUT_SIZE*INPUT_P  requester r occupies slice [r*INPUT_SIZE*INPUT_P +: INPUT_SIZE*INPUT_P]; element i at [i*INPUT_P +: INPUT_P] within it
req_addr  in  NUM_REQ*ADDR_W  per-requester column address
eng_en  out  1  engine compute enable
eng_bits  out  INPUT_SIZE  current bit-plane; bit i = bit k of element i
eng_addr  out  ADDR_W  engine column address
eng_result  in  ADC_P  engine ADC output; registered in engine, valid 1 cycle after eng_en
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_id  out  ID_W  index of requester that owns the result
rsp_data  out  ACC_W  accumulated result
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, COMPUTE, DRAIN, RESP. Reset state is IDLE.
- Async reset clears: state, plane counter, RR pointer (=0), acc, latched job, all outputs (=0).
- Reset mid-job discards the job. No response is produced for it.
- IDLE: grant g = first index with req_valid set, searching cyclically from ptr. req_ready = onehot(g) combinationally, only in IDLE and only when any req_valid is set.
- On handshake (IDLE, req_valid[g]):
  - latch feature, addr and id=g
  - ptr <= (g+1) mod NUM_REQ
  - k <= 0, acc <= 0
  - next state COMPUTE
- COMPUTE lasts exactly INPUT_P cycles. In each cycle, eng_en=1, eng_bits = plane k of latched feature, eng_addr = latched addr, and k increments. After plane INPUT_P-1, go to DRAIN.
- eng_en, eng_bits and eng_addr decode from registered state only. eng_bits=0 and eng_en=0 outside COMPUTE. eng_addr holds the last value.
- Accumulate: a delayed flag and a plane index track each issue. On the edge ending the cycle after plane k is issued, acc <= acc + (eng_result << k), zero-extended to ACC_W.
- Overflow is impossible: max (2^ADC_P-1)(2^INPUT_P-1) < 2^ACC_W.
- DRAIN: one cycle; captures the plane INPUT_P-1 result; next state RESP.
- Latency: rsp_valid rises INPUT_P+1 edges after the accept edge.
- RESP: rsp_valid=1. rsp_id and rsp_data stay stable until rsp_ready is sampled high, then return to IDLE.
- No new accept in the RESP-handshake cycle. Minimum job spacing is INPUT_P+3 cycles.
- rsp_valid is independent of rsp_ready; rsp_ready may be held high permanently.
- Unselected requesters must hold valid and data. Their req_ready stays 0 outside IDLE.
- A requester dropping req_valid before grant is legal and is simply skipped.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ-1 to 0.

Test Plan:
- Engine model: registered popcount(eng_bits) clipped to ADC_P. Params: NUM_REQ=4, INPUT_SIZE=9, INPUT_P=8, ADC_P=4.
- Single job, req 2, all elements 0xFF, addr 1 -> eng_en high 8 consecutive cycles, eng_addr=1, rsp_valid 9 edges after accept, rsp_id=2, rsp_data=2295.
- Req 0, element0=0x05, others 0 -> eng_bits=9'h001 only on planes 0 and 2, rsp_data=5. All elements 0x80 -> rsp_data=1152.
- All 4 req_valid held high, rsp_ready=1, 5 jobs -> grant order 0,1,2,3,0, each req_ready pulse exactly 1 cycle, busy low for exactly 1 cycle between jobs.
- rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable throughout; req_ready stays 0 while req_valid=4'hF; next grant occurs 1 cycle after the handshake.
- rst asserted asynchronously during COMPUTE plane 3 -> eng_en, busy, rsp_valid go 0 immediately without a clock edge; ptr=0; no stale response. Post-reset job from req 3 with 0x01 elements returns rsp_data=9.

Source files
------------

// File: rtl/pim_conv_sched.sv
// Round-robin scheduler sharing one bit-serial PIM crossbar conv engine among NUM_REQ requesters.
// Streams each job's bit-planes into the engine and shift-accumulates the ADC partial sums.
module pim_conv_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned INPUT_SIZE = 9,
    parameter int unsigned INPUT_P    = 8,
    parameter int unsigned ADC_P      = 4,
    parameter int unsigned ADDR_W     = 1,
    parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned ACC_W      = ADC_P + INPUT_P
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*INPUT_SIZE*INPUT_P-1:0] req_feature,
    input  logic [NUM_REQ*ADDR_W-1:0]             req_addr,
    output logic                                  eng_en,
    output logic [INPUT_SIZE-1:0]                 eng_bits,
    output logic [ADDR_W-1:0]                     eng_addr,
    input  logic [ADC_P-1:0]                      eng_result,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [ID_W-1:0]                       rsp_id,
    output logic [ACC_W-1:0]                      rsp_data,
    output logic                                  busy
);

    localparam int unsigned FEAT_W = INPUT_SIZE * INPUT_P;
    localparam int unsigned K_W    = (INPUT_P > 1) ? $clog2(INPUT_P) : 1;
    localparam int unsigned I_W    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(INPUT_P - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                                   state;
    logic [ID_W-1:0]                          ptr;
    logic [ID_W-1:0]                          job_id;
    logic [INPUT_SIZE-1:0][INPUT_P-1:0]       job_feat;
    logic [ADDR_W-1:0]                        job_addr;
    logic [K_W-1:0]                           k;
    logic [K_W-1:0]                           acc_k;
    logic                                     acc_en;
    logic [ACC_W-1:0]                         acc;
    logic [ID_W-1:0]                          gnt;
    logic [ID_W-1:0]                          idx;
    logic                                     gnt_vld;
    logic [ID_W-1:0]                          ptr_nxt;

    // First valid requester searching cyclically from ptr; the lowest offset wins.
    always_comb begin
        gnt     = ptr;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (req_valid[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
        ptr_nxt = ID_W'((int'(gnt) + 1) % int'(NUM_REQ));
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Engine drive decodes straight from registered job state.
    always_comb begin
        eng_bits = '0;
        if (state == COMPUTE) begin
            for (int i = 0; i < int'(INPUT_SIZE); i++) begin
                eng_bits[i] = job_feat[I_W'(i)][k];
            end
        end
    end

    assign eng_en    = (state == COMPUTE);
    assign eng_addr  = job_addr;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = job_id;
    assign rsp_data  = acc;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            job_id   <= '0;
            job_feat <= '0;
            job_addr <= '0;
            k        <= '0;
            acc_k    <= '0;
            acc_en   <= 1'b0;
            acc      <= '0;
        end else begin
            // Engine result lags the issued plane by one cycle.
            acc_en <= eng_en;
            acc_k  <= k;
            if (acc_en) begin
                acc <= acc + (ACC_W'(eng_result) << acc_k);
            end
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        job_feat <= req_feature[FEAT_W*gnt +: FEAT_W];
                        job_addr <= req_addr[ADDR_W*gnt +: ADDR_W];
                        job_id   <= gnt;
                        ptr      <= ptr_nxt;
                        k        <= '0;
                        acc      <= '0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                DRAIN: state <= RESP;
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_conv_sched.sv
// Self-checking bench for pim_conv_sched: per-cycle job-timeline model plus directed scenarios.
// The engine is modelled as a registered popcount of the bit-plane clipped to ADC_P bits.
module tb_pim_conv_sched;

    localparam int NR   = 4;
    localparam int IS   = 9;
    localparam int IP   = 8;
    localparam int AP   = 4;
    localparam int AW   = 1;
    localparam int IDW  = 2;
    localparam int ACCW = AP + IP;
    localparam int FW   = IS * IP;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*FW-1:0]   req_feature = '0;
    logic [NR*AW-1:0]   req_addr = '0;
    logic               eng_en;
    logic [IS-1:0]      eng_bits;
    logic [AW-1:0]      eng_addr;
    logic [AP-1:0]      eng_result;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [ACCW-1:0]    rsp_data;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pim_conv_sched #(
        .NUM_REQ(NR), .INPUT_SIZE(IS), .INPUT_P(IP), .ADC_P(AP), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_feature(req_feature), .req_addr(req_addr),
        .eng_en(eng_en), .eng_bits(eng_bits), .eng_addr(eng_addr),
        .eng_result(eng_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AP-1:0] clip_pc(input logic [IS-1:0] b);
        int c = 0;
        for (int i = 0; i < IS; i++) c += int'(b[i]);
        if (c > (1 << AP) - 1) c = (1 << AP) - 1;
        return AP'(c);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) eng_result <= '0;
        else      eng_result <= clip_pc(eng_bits);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [IS-1:0] plane(input logic [FW-1:0] f, input int kk);
        logic [IS-1:0] b = '0;
        for (int i = 0; i < IS; i++) b[i] = f[i*IP + kk];
        return b;
    endfunction

    function automatic int job_result(input logic [FW-1:0] f);
        int r = 0;
        for (int kk = 0; kk < IP; kk++) r += int'(clip_pc(plane(f, kk))) << kk;
        return r;
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int i = 0; i < NR; i++) if (v[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    // m_phase: -1 idle, 0..IP-1 plane issue, IP drain, IP+1 response
    int             m_phase = -1;
    int             m_ptr = 0;
    int             m_id = 0;
    int             m_res = 0;
    int             m_g;
    logic [FW-1:0]  m_feat = '0;
    logic [AW-1:0]  m_addr = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = -1; m_ptr = 0; m_id = 0; m_res = 0; m_feat = '0; m_addr = '0;
        end else if (m_phase < 0) begin
            m_g = pick(req_valid, m_ptr);
            if (m_g >= 0) begin
                m_feat  = req_feature[m_g*FW +: FW];
                m_addr  = req_addr[m_g*AW +: AW];
                m_id    = m_g;
                m_res   = job_result(m_feat);
                m_ptr   = (m_g + 1) % NR;
                m_phase = 0;
            end
        end else if (m_phase < IP + 1) begin
            m_phase++;
        end else if (rsp_ready) begin
            m_phase = -1;
        end
    end

    logic [NR-1:0] exp_ready;
    int            c_g;
    always @(negedge clk) begin
        if (rst) begin
            exp_ready = '0;
            if (m_phase < 0) begin
                c_g = pick(req_valid, m_ptr);
                if (c_g >= 0) exp_ready[c_g] = 1'b1;
            end
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, m_phase >= 0);
            check("eng_en", eng_en, m_phase >= 0 && m_phase < IP);
            check("eng_bits", eng_bits, (m_phase >= 0 && m_phase < IP) ? plane(m_feat, m_phase) : '0);
            check("eng_addr", eng_addr, m_addr);
            check("rsp_valid", rsp_valid, m_phase == IP + 1);
            if (m_phase == IP + 1) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_res);
            end
        end
    end

    // ---------------- event monitor ----------------
    int            acc_edge_q[$], acc_id_q[$], rise_q[$];
    int            rsp_edge_q[$], rsp_id_q[$], rsp_data_q[$];
    logic [IS-1:0] bits_q[$];
    int            en_cnt = 0, rdy_cnt = 0, blo_cnt = 0;
    logic          prev_rv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
        end else begin
            if ((req_ready & req_valid) != '0) begin
                acc_edge_q.push_back(cyc + 1);
                for (int i = 0; i < NR; i++) if (req_ready[i]) acc_id_q.push_back(i);
            end
            if (rsp_valid && !prev_rv) rise_q.push_back(cyc);
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                rsp_edge_q.push_back(cyc + 1);
                rsp_id_q.push_back(int'(rsp_id));
                rsp_data_q.push_back(int'(rsp_data));
            end
            if (eng_en) begin
                en_cnt++;
                bits_q.push_back(eng_bits);
            end
            if (req_ready != '0) rdy_cnt++;
            if (!busy) blo_cnt++;
        end
    end

    task automatic clear_mon();
        acc_edge_q.delete(); acc_id_q.delete(); rise_q.delete();
        rsp_edge_q.delete(); rsp_id_q.delete(); rsp_data_q.delete(); bits_q.delete();
        en_cnt = 0; rdy_cnt = 0; blo_cnt = 0;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return acc_edge_q.size();
            1:       return rsp_edge_q.size();
            default: return rise_q.size();
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int n, input string name);
        int i = 0;
        while (qsize(which) < n && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, qsize(which) >= n, 1);
    endtask

    task automatic set_feat(input int r, input logic [7:0] v);
        for (int i = 0; i < IS; i++) req_feature[r*FW + i*IP +: IP] = v;
    endtask

    int nz;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset eng_en", eng_en, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset eng_addr", eng_addr, 0);
        check("reset req_ready", req_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single job from requester 2, all 0xFF, addr 1
        clear_mon();
        set_feat(2, 8'hFF);
        req_addr = 4'b0100;
        req_valid = 4'b0100;
        wait_cnt(0, 1, "t1 accept");
        req_valid = '0;
        wait_cnt(1, 1, "t1 response");
        check("t1 grant id", acc_id_q[0], 2);
        check("t1 eng_en cycles", en_cnt, 8);
        check("t1 latency", rise_q[0] - acc_edge_q[0], 9);
        check("t1 rsp_id", rsp_id_q[0], 2);
        check("t1 rsp_data", rsp_data_q[0], 2295);
        check("t1 eng_addr held", eng_addr, 1);

        // Requester 0, element0 = 0x05
        clear_mon();
        set_feat(0, 8'h00);
        req_feature[7:0] = 8'h05;
        req_addr = '0;
        req_valid = 4'b0001;
        wait_cnt(0, 1, "t2a accept");
        req_valid = '0;
        wait_cnt(1, 1, "t2a response");
        nz = 0;
        foreach (bits_q[i]) if (bits_q[i] != '0) nz++;
        check("t2a plane0", bits_q[0], 9'h001);
        check("t2a plane2", bits_q[2], 9'h001);
        check("t2a nonzero planes", nz, 2);
        check("t2a rsp_data", rsp_data_q[0], 5);

        // Requester 3, all 0x80 (also leaves the pointer at 0)
        clear_mon();
        set_feat(3, 8'h80);
        req_valid = 4'b1000;
        wait_cnt(0, 1, "t2b accept");
        req_valid = '0;
        wait_cnt(1, 1, "t2b response");
        check("t2b rsp_id", rsp_id_q[0], 3);
        check("t2b rsp_data", rsp_data_q[0], 1152);

        // All requesters valid, five back-to-back jobs
        clear_mon();
        for (int r = 0; r < NR; r++) set_feat(r, 8'(8'h11 * (r + 1)));
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        wait_cnt(0, 5, "t3 accepts");
        req_valid = '0;
        wait_cnt(1, 5, "t3 responses");
        for (int i = 0; i < 5; i++) check("t3 grant order", acc_id_q[i], i % NR);
        for (int i = 0; i < 4; i++) check("t3 job spacing", acc_edge_q[i+1] - acc_edge_q[i], IP + 3);
        check("t3 ready cycles", rdy_cnt, 5);
        check("t3 idle cycles", blo_cnt, 5);

        // Back-pressure on the response channel
        clear_mon();
        for (int r = 0; r < NR; r++) set_feat(r, 8'h0F);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        wait_cnt(0, 1, "t4 accept");
        wait_cnt(2, 1, "t4 rsp rise");
        repeat (5) begin
            @(negedge clk);
            check("t4 rsp_valid stable", rsp_valid, 1);
            check("t4 rsp_id stable", rsp_id, 1);
            check("t4 rsp_data stable", rsp_data, 135);
            check("t4 req_ready low", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_cnt(0, 2, "t4 next accept");
        req_valid = '0;
        wait_cnt(1, 2, "t4 responses");
        check("t4 first grant", acc_id_q[0], 1);
        check("t4 next grant", acc_id_q[1], 2);
        check("t4 regrant gap", acc_edge_q[1] - rsp_edge_q[0], 1);
        check("t4 second data", rsp_data_q[1], 135);

        // Asynchronous reset during plane 3
        clear_mon();
        set_feat(1, 8'hFF);
        req_valid = 4'b0010;
        wait_cnt(0, 1, "t5 accept");
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("t5 computing before reset", eng_en, 1);
        #2 rst = 1'b0;
        #1;
        check("t5 eng_en async", eng_en, 0);
        check("t5 busy async", busy, 0);
        check("t5 rsp_valid async", rsp_valid, 0);
        check("t5 rsp_data async", rsp_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
        req_valid = 4'hF;
        #1;
        check("t5 ptr cleared", req_ready, 4'b0001);
        set_feat(3, 8'h01);
        req_valid = 4'b1000;
        wait_cnt(0, 1, "t5 post accept");
        req_valid = '0;
        wait_cnt(1, 1, "t5 post response");
        repeat (3) @(posedge clk);
        #1;
        check("t5 response count", rsp_edge_q.size(), 1);
        check("t5 rsp_id", rsp_id_q[0], 3);
        check("t5 rsp_data", rsp_data_q[0], 9);
        check("t5 latency", rise_q[0] - acc_edge_q[0], 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
